// File: rtl/spi_frame_sequencer.sv
// ---------------------------------------------------------------------------
// spi_frame_sequencer
//
// Runs one mode-0 SPI word transfer for each channel selected in a start mask,
// lowest channel first, over a shared SCLK/MOSI/MISO bus with one active-low
// chip select per channel. Mask, gap and transmit words are captured when a
// batch is triggered. Each received word is stored per channel. end_spi is
// raised when the batch completes.
//
// Ports
//   clk_clk, reset_reset_n      system clock, asynchronous active-low reset
//   start_spi[5:0]              channel start mask; a rising bit triggers
//   delay_spi[7:0]              inter-frame gap, delay_spi+1 cycles
//   tx_data_0..5                transmit words
//   rx_data_0..5                received words, hold until overwritten
//   end_spi                     batch-done level, cleared at next trigger
//   busy                        high from trigger until batch done
//   spi_sclk/spi_mosi/spi_miso  serial bus, CPOL=0 CPHA=0, MSB first
//   spi_cs_n[5:0]               chip selects, at most one low
// ---------------------------------------------------------------------------
module spi_frame_sequencer #(
    parameter int CLK_DIV = 4,   // SCLK half-period in clk cycles, 2..255
    parameter int WORD_W  = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [5:0]        start_spi,
    input  logic [7:0]        delay_spi,
    input  logic [WORD_W-1:0] tx_data_0,
    input  logic [WORD_W-1:0] tx_data_1,
    input  logic [WORD_W-1:0] tx_data_2,
    input  logic [WORD_W-1:0] tx_data_3,
    input  logic [WORD_W-1:0] tx_data_4,
    input  logic [WORD_W-1:0] tx_data_5,
    output logic [WORD_W-1:0] rx_data_0,
    output logic [WORD_W-1:0] rx_data_1,
    output logic [WORD_W-1:0] rx_data_2,
    output logic [WORD_W-1:0] rx_data_3,
    output logic [WORD_W-1:0] rx_data_4,
    output logic [WORD_W-1:0] rx_data_5,
    output logic              end_spi,
    output logic              busy,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [5:0]        spi_cs_n
);

    localparam int              NCH      = 6;
    localparam int              BW       = $clog2(WORD_W);
    localparam logic [7:0]      DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(WORD_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETUP,
        S_SHIFT_HI,
        S_SHIFT_LO,
        S_HOLD,
        S_GAP,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [5:0]          start_q;
    logic [5:0]          mask_q;
    logic [7:0]          gap_q;
    logic [WORD_W-1:0]   tx_q [NCH];
    logic [WORD_W-1:0]   rx_q [NCH];
    logic [WORD_W-1:0]   shift_q;
    logic [WORD_W-1:0]   rx_shift_q;
    logic [2:0]          ch_q;
    logic [2:0]          idx_q;     // search start for the next SELECT
    logic [7:0]          cnt_q;     // cycles spent in the current state
    logic [BW-1:0]       bit_q;     // SCLK high phases completed this frame
    logic                end_q;
    logic                busy_q;

    logic [WORD_W-1:0]   tx_in [NCH];
    logic                trig;
    logic                phase_done;
    logic                gap_done;
    logic                last_bit;
    logic                sel_found;
    logic [2:0]          sel_ch;
    logic [5:0]          mask_left;

    assign tx_in[0] = tx_data_0;
    assign tx_in[1] = tx_data_1;
    assign tx_in[2] = tx_data_2;
    assign tx_in[3] = tx_data_3;
    assign tx_in[4] = tx_data_4;
    assign tx_in[5] = tx_data_5;

    assign rx_data_0 = rx_q[0];
    assign rx_data_1 = rx_q[1];
    assign rx_data_2 = rx_q[2];
    assign rx_data_3 = rx_q[3];
    assign rx_data_4 = rx_q[4];
    assign rx_data_5 = rx_q[5];

    assign end_spi = end_q;
    assign busy    = busy_q;

    // Edges outside IDLE are dropped; start_q still tracks every cycle so a
    // held bit cannot retrigger once the batch ends.
    assign trig       = (state_q == S_IDLE) && (|(start_spi & ~start_q));
    assign phase_done = (cnt_q == DIV_LAST);
    assign gap_done   = (cnt_q == gap_q);
    assign last_bit   = (bit_q == BIT_LAST);
    assign mask_left  = mask_q & ~(6'b000001 << ch_q);

    // Lowest pending channel at or above idx_q; iterate downward so the
    // lowest match is the one left standing.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_q[i] && (i >= int'(idx_q))) begin
                sel_found = 1'b1;
                sel_ch    = 3'(i);
            end
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state_q <= S_IDLE;
        else                state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (trig) state_d = S_SELECT;
            S_SELECT:   state_d = sel_found ? S_SETUP : S_DONE;
            S_SETUP:    if (phase_done) state_d = S_SHIFT_HI;
            S_SHIFT_HI: if (phase_done) state_d = last_bit ? S_HOLD : S_SHIFT_LO;
            S_SHIFT_LO: if (phase_done) state_d = S_SHIFT_HI;
            // GAP is skipped when nothing is left; SELECT then finds no bit.
            S_HOLD:     if (phase_done) state_d = (mask_left != 6'd0) ? S_GAP : S_SELECT;
            S_GAP:      if (gap_done) state_d = S_SELECT;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // Bus pins decode straight from the registered state, so a reset returns
    // them to idle levels at once.
    always_comb begin
        spi_cs_n = 6'h3F;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        case (state_q)
            S_SETUP, S_SHIFT_HI, S_SHIFT_LO, S_HOLD: begin
                spi_cs_n = ~(6'b000001 << ch_q);
                spi_mosi = shift_q[WORD_W-1];
                spi_sclk = (state_q == S_SHIFT_HI);
            end
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            start_q    <= '0;
            mask_q     <= '0;
            gap_q      <= '0;
            shift_q    <= '0;
            rx_shift_q <= '0;
            ch_q       <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            bit_q      <= '0;
            end_q      <= 1'b0;
            busy_q     <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                tx_q[i] <= '0;
                rx_q[i] <= '0;
            end
        end else begin
            start_q <= start_spi;

            // Restart the cycle counter on every state change.
            if (state_d != state_q || state_q == S_IDLE) cnt_q <= '0;
            else                                         cnt_q <= cnt_q + 8'd1;

            if (trig) begin
                mask_q <= start_spi;
                gap_q  <= delay_spi;
                idx_q  <= '0;
                end_q  <= 1'b0;
                busy_q <= 1'b1;
                for (int i = 0; i < NCH; i++) tx_q[i] <= tx_in[i];
            end

            if (state_q == S_SELECT && sel_found) begin
                ch_q    <= sel_ch;
                shift_q <= tx_q[sel_ch];
                bit_q   <= '0;
            end

            // MISO is taken on the edge that raises SCLK.
            if (state_d == S_SHIFT_HI && state_q != S_SHIFT_HI)
                rx_shift_q <= {rx_shift_q[WORD_W-2:0], spi_miso};

            // Next MOSI bit is presented on the edge that drops SCLK.
            if (state_d == S_SHIFT_LO && state_q != S_SHIFT_LO)
                shift_q <= {shift_q[WORD_W-2:0], 1'b0};

            if (state_q == S_SHIFT_HI && phase_done)
                bit_q <= bit_q + 1'b1;

            if (state_q == S_HOLD && phase_done) begin
                rx_q[ch_q] <= rx_shift_q;
                mask_q     <= mask_left;
                idx_q      <= ch_q + 3'd1;
            end

            if (state_q == S_DONE) begin
                end_q  <= 1'b1;
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
module tb_spi_frame_sequencer;

    localparam int D = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  start = '0;
    logic [7:0]  dly   = '0;
    logic [15:0] tx_in [6];
    logic [15:0] rx_out [6];
    logic        end_spi, busy, sclk, mosi, miso;
    logic [5:0]  cs_n;

    // slave side
    logic        loopback = 1'b1;
    logic [15:0] slv_word [6];
    logic [15:0] sreg = '0;
    logic [5:0]  s_pcs = 6'h3F;
    logic        s_psclk = 1'b0;

    // model state (written only by the compare process)
    typedef struct packed {
        logic [5:0] cs;
        logic       sclk;
        logic       mosi;
    } exp_t;
    exp_t        q[$];
    exp_t        ce;
    logic [15:0] m_rx [6];
    logic [15:0] p_rx [6];
    logic [15:0] cap_tx [6];
    logic        m_end = 1'b0;
    logic [5:0]  prev_start = '0;

    // free-running event counters
    int cs_low_cnt = 0, sclk_rise = 0, end_rise = 0;
    logic k_psclk = 1'b0, k_pend = 1'b0;

    int c_chk = 0, c_pass = 0, m_chk = 0, m_pass = 0;

    always #5 clk = ~clk;

    assign miso = loopback ? mosi : sreg[15];

    spi_frame_sequencer #(.CLK_DIV(D), .WORD_W(16)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .start_spi(start), .delay_spi(dly),
        .tx_data_0(tx_in[0]), .tx_data_1(tx_in[1]), .tx_data_2(tx_in[2]),
        .tx_data_3(tx_in[3]), .tx_data_4(tx_in[4]), .tx_data_5(tx_in[5]),
        .rx_data_0(rx_out[0]), .rx_data_1(rx_out[1]), .rx_data_2(rx_out[2]),
        .rx_data_3(rx_out[3]), .rx_data_4(rx_out[4]), .rx_data_5(rx_out[5]),
        .end_spi(end_spi), .busy(busy),
        .spi_sclk(sclk), .spi_mosi(mosi), .spi_miso(miso), .spi_cs_n(cs_n)
    );

    // Mode-0 slave: load on CS fall, advance on SCLK fall.
    always @(negedge clk) begin
        if (s_pcs == 6'h3F && cs_n != 6'h3F) begin
            for (int i = 0; i < 6; i++) if (!cs_n[i]) sreg = slv_word[i];
        end else if (s_psclk && !sclk && cs_n != 6'h3F) begin
            sreg = {sreg[14:0], 1'b0};
        end
        s_pcs   = cs_n;
        s_psclk = sclk;
    end

    always @(negedge clk) begin
        if (cs_n != 6'h3F) cs_low_cnt++;
        if (!k_psclk && sclk) sclk_rise++;
        if (!k_pend && end_spi) end_rise++;
        k_psclk = sclk;
        k_pend  = end_spi;
    end

    task automatic cchk(input string nm, input logic [31:0] a, input logic [31:0] e);
        c_chk++;
        if (a === e) c_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", nm, $time, a, e);
    endtask

    task automatic mchk(input string nm, input logic [31:0] a, input logic [31:0] e);
        m_chk++;
        if (a === e) m_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", nm, $time, a, e);
    endtask

    task automatic chk_idle();
        cchk("idle_cs_n", cs_n, 6'h3F);
        cchk("idle_sclk", sclk, 1'b0);
        cchk("idle_mosi", mosi, 1'b0);
        cchk("idle_busy", busy, 1'b0);
        cchk("idle_end", end_spi, m_end);
        for (int i = 0; i < 6; i++) cchk("rx_data", rx_out[i], m_rx[i]);
    endtask

    // Expected per-cycle bus activity from the trigger onward, straight from
    // the frame timing rules: SELECT, then per channel 33 half-periods of CS
    // low (setup, 16 high / 15 low, hold), then gap+SELECT or SELECT+DONE.
    task automatic build_batch(input logic [5:0] mask, input logic [7:0] gap);
        exp_t e;
        int last;
        last = -1;
        for (int i = 0; i < 6; i++) begin
            if (mask[i]) last = i;
            p_rx[i] = m_rx[i];
        end
        e.cs = 6'h3F; e.sclk = 1'b0; e.mosi = 1'b0;
        q.push_back(e);
        for (int ch = 0; ch < 6; ch++) begin
            if (mask[ch]) begin
                for (int o = 0; o < 33 * D; o++) begin
                    int p = o / D;
                    int b = (p / 2 > 15) ? 15 : p / 2;
                    e.cs   = ~(6'd1 << ch);
                    e.sclk = (p % 2 == 1) && (p < 32);
                    e.mosi = cap_tx[ch][15 - b];
                    q.push_back(e);
                end
                p_rx[ch] = loopback ? cap_tx[ch] : slv_word[ch];
                e.cs = 6'h3F; e.sclk = 1'b0; e.mosi = 1'b0;
                if (ch != last) begin
                    for (int g = 0; g < int'(gap) + 2; g++) q.push_back(e);
                end else begin
                    q.push_back(e);
                    q.push_back(e);
                end
            end
        end
    endtask

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_end = 1'b0;
            for (int i = 0; i < 6; i++) m_rx[i] = '0;
            prev_start = '0;
            chk_idle();
        end else if (q.size() != 0) begin
            ce = q.pop_front();
            cchk("cs_n", cs_n, ce.cs);
            cchk("sclk", sclk, ce.sclk);
            cchk("mosi", mosi, ce.mosi);
            cchk("busy", busy, 1'b1);
            cchk("end_spi", end_spi, 1'b0);
            if (q.size() == 0) begin
                m_end = 1'b1;
                for (int i = 0; i < 6; i++) m_rx[i] = p_rx[i];
            end
            prev_start = start;
        end else begin
            chk_idle();
            if ((start & ~prev_start) != 6'd0) begin
                for (int i = 0; i < 6; i++) cap_tx[i] = tx_in[i];
                build_batch(start, dly);
            end
            prev_start = start;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        tick(); tick();
        for (int k = 0; k < 20000 && q.size() != 0; k++) tick();
        mchk("batch_done", q.size(), 0);
        tick(); tick();
    endtask

    int b_cs, b_sr, b_er;

    initial begin
        for (int i = 0; i < 6; i++) begin
            tx_in[i]    = '0;
            slv_word[i] = '0;
        end
        repeat (3) @(posedge clk);
        #2;
        mchk("rst_cs_n", cs_n, 6'h3F);
        mchk("rst_busy", busy, 1'b0);
        mchk("rst_end", end_spi, 1'b0);
        mchk("rst_rx0", rx_out[0], 16'h0000);
        rst_n = 1'b1;
        tick(); tick();

        // single channel, loopback
        loopback = 1'b1; tx_in[0] = 16'hA5C3; dly = 8'd0;
        b_cs = cs_low_cnt; b_sr = sclk_rise;
        start = 6'b000001;
        wait_idle();
        mchk("single_cs_low_cycles", cs_low_cnt - b_cs, 132);
        mchk("single_sclk_pulses", sclk_rise - b_sr, 16);
        mchk("single_rx0", rx_out[0], 16'hA5C3);
        mchk("single_end", end_spi, 1'b1);
        mchk("single_busy", busy, 1'b0);
        start = '0; tick();

        // all six channels, slave words
        loopback = 1'b0; dly = 8'd9;
        for (int i = 0; i < 6; i++) begin
            tx_in[i]    = 16'(16'h1111 * (i + 1));
            slv_word[i] = 16'hF000 + 16'(i);
        end
        b_cs = cs_low_cnt; b_sr = sclk_rise;
        start = 6'h3F;
        wait_idle();
        mchk("six_cs_low_cycles", cs_low_cnt - b_cs, 6 * 132);
        mchk("six_sclk_pulses", sclk_rise - b_sr, 96);
        for (int i = 0; i < 6; i++) mchk("six_rx", rx_out[i], 16'hF000 + 16'(i));
        start = '0; tick();

        // sparse mask after seeding the other channels with 1234
        loopback = 1'b1; dly = 8'd3;
        for (int i = 0; i < 6; i++) tx_in[i] = 16'h1234;
        start = 6'b011011;
        wait_idle();
        start = '0; tick();
        loopback = 1'b0;
        start = 6'b100100;
        wait_idle();
        mchk("sparse_rx0", rx_out[0], 16'h1234);
        mchk("sparse_rx1", rx_out[1], 16'h1234);
        mchk("sparse_rx2", rx_out[2], 16'hF002);
        mchk("sparse_rx3", rx_out[3], 16'h1234);
        mchk("sparse_rx4", rx_out[4], 16'h1234);
        mchk("sparse_rx5", rx_out[5], 16'hF005);
        start = '0; tick();

        // retrigger and tx change mid-batch are ignored
        loopback = 1'b1; tx_in[0] = 16'h5A0F;
        b_er = end_rise;
        start = 6'b000001;
        repeat (50) tick();
        start = 6'b001001;
        tx_in[0] = 16'hFFFF;
        wait_idle();
        mchk("retrig_rx0", rx_out[0], 16'h5A0F);
        mchk("retrig_rx3", rx_out[3], 16'h1234);
        mchk("retrig_end_rises", end_rise - b_er, 1);
        start = '0; tick();

        // async reset during the 8th SCLK high phase
        tx_in[1] = 16'h0F0F;
        b_sr = sclk_rise;
        start = 6'b000010;
        for (int k = 0; k < 2000 && (sclk_rise - b_sr) < 8; k++) tick();
        mchk("reset_reached_sclk8", sclk_rise - b_sr, 8);
        mchk("reset_sclk_before", sclk, 1'b1);
        rst_n = 1'b0;
        start = '0;
        #1;
        mchk("reset_cs_n", cs_n, 6'h3F);
        mchk("reset_sclk", sclk, 1'b0);
        mchk("reset_busy", busy, 1'b0);
        mchk("reset_end", end_spi, 1'b0);
        mchk("reset_rx0", rx_out[0], 16'h0000);
        mchk("reset_rx1", rx_out[1], 16'h0000);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();

        // level-held start gives one batch; a fresh edge gives another
        b_er = end_rise;
        loopback = 1'b1; tx_in[1] = 16'hC3A5;
        start = 6'b000010;
        wait_idle();
        repeat (300) tick();
        mchk("held_end_rises", end_rise - b_er, 1);
        mchk("held_busy", busy, 1'b0);
        mchk("held_rx1", rx_out[1], 16'hC3A5);
        start = '0; tick();
        start = 6'b000010; tick();
        mchk("held_end_drop", end_spi, 1'b0);
        mchk("held_busy_set", busy, 1'b1);
        wait_idle();
        mchk("held_end_rises2", end_rise - b_er, 2);
        start = '0; tick();

        // randomized batches
        for (int it = 0; it < 8; it++) begin
            loopback = 1'($urandom_range(0, 1));
            for (int i = 0; i < 6; i++) begin
                tx_in[i]    = 16'($urandom);
                slv_word[i] = 16'($urandom);
            end
            dly = (it == 3) ? 8'd255 : 8'($urandom_range(0, 12));
            start = 6'($urandom_range(1, 63));
            repeat ($urandom_range(5, 100)) tick();
            start = 6'($urandom);
            for (int i = 0; i < 6; i++) tx_in[i] = 16'($urandom);
            wait_idle();
            start = '0; tick();
        end

        $display("%0d/%0d checks passed", c_pass + m_pass, c_chk + m_chk);
        $finish;
    end

endmodule
